// File: rtl/rv32i_top_proc_if.sv
// rv32i_top_proc_if
//   Bus bundle between the rv32i_top_proc core and its external memories.
//   The instruction ROM and the data RAM are both synchronous-read.
//
//   master (core side):
//     PC            out  32  fetch byte address to the instruction ROM
//     instr         in   32  ROM word, registered by the ROM
//     dAddress      out  32  data RAM byte address (0 outside MEM)
//     dWriteData    out  32  store data (0 outside MEM)
//     dReadData     in   32  RAM read data, registered by the RAM
//     MemRead       out   1  LW access in MEM
//     MemWrite      out   1  SW access in MEM
//     WriteBackData out  32  value written to rd (0 outside WB)
//   slave (memory / environment side): same signals, opposite directions.
interface rv32i_top_proc_if;
    logic [31:0] PC;
    logic [31:0] instr;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] WriteBackData;

    modport master (
        output PC, dAddress, dWriteData, MemRead, MemWrite, WriteBackData,
        input  instr, dReadData
    );

    modport slave (
        input  PC, dAddress, dWriteData, MemRead, MemWrite, WriteBackData,
        output instr, dReadData
    );
endinterface

// File: rtl/rv32i_top_proc.sv
// rv32i_top_proc
//   Multicycle RV32I-subset core. Every instruction walks the fixed state
//   sequence IF -> ID -> EX -> MEM -> WB and takes exactly five cycles.
//   Supported: ADD SUB AND OR XOR SLT, ADDI ANDI ORI XORI SLTI, LW SW BEQ.
//   Every other encoding executes as a NOP (no writes, PC + 4).
//
//   Optional feature: define TOP_PROC_SHIFT_EN to add SLL SRL SRA SLLI
//   SRLI SRAI. Without it, shift encodings are NOPs and no shifter exists.
//
//   Ports:
//     clk   in   system clock, rising-edge
//     rst   in   asynchronous active-high reset
//     bus   master modport of rv32i_top_proc_if (ROM, RAM, write-back)
//   Parameter:
//     INITIAL_PC  byte address loaded into the PC on reset
module rv32i_top_proc #(
    parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
    input  logic              clk,
    input  logic              rst,
    rv32i_top_proc_if.master  bus
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
`ifdef TOP_PROC_SHIFT_EN
        ,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
`endif
    } alu_op_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] alu_q;
    logic        zero_q;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b;

    assign opcode = bus.instr[6:0];
    assign rd     = bus.instr[11:7];
    assign funct3 = bus.instr[14:12];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign funct7 = bus.instr[31:25];

    assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                    bus.instr[30:25], bus.instr[11:8], 1'b0};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    alu_op_e     alu_op;
    logic        use_imm;
    logic [31:0] imm;
    logic        reg_write;
    logic        is_lw, is_sw, is_beq;

    always_comb begin
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        imm       = imm_i;
        reg_write = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;

        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: alu_op = ALU_ADD;
                    {F7_ALT,  3'b000}: alu_op = ALU_SUB;
                    {F7_BASE, 3'b111}: alu_op = ALU_AND;
                    {F7_BASE, 3'b110}: alu_op = ALU_OR;
                    {F7_BASE, 3'b100}: alu_op = ALU_XOR;
                    {F7_BASE, 3'b010}: alu_op = ALU_SLT;
`ifdef TOP_PROC_SHIFT_EN
                    {F7_BASE, 3'b001}: alu_op = ALU_SLL;
                    {F7_BASE, 3'b101}: alu_op = ALU_SRL;
                    {F7_ALT,  3'b101}: alu_op = ALU_SRA;
`endif
                    default:           reg_write = 1'b0;
                endcase
            end
            OP_I: begin
                use_imm   = 1'b1;
                reg_write = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b100:  alu_op = ALU_XOR;
                    3'b010:  alu_op = ALU_SLT;
`ifdef TOP_PROC_SHIFT_EN
                    // Shift-immediates reuse imm[11:5] as funct7.
                    3'b001: begin
                        if (funct7 == F7_BASE) alu_op = ALU_SLL;
                        else                   reg_write = 1'b0;
                    end
                    3'b101: begin
                        if      (funct7 == F7_BASE) alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT)  alu_op = ALU_SRA;
                        else                        reg_write = 1'b0;
                    end
`endif
                    default: reg_write = 1'b0;
                endcase
            end
            OP_LW: begin
                if (funct3 == 3'b010) begin
                    is_lw     = 1'b1;
                    reg_write = 1'b1;
                    use_imm   = 1'b1;
                end
            end
            OP_SW: begin
                if (funct3 == 3'b010) begin
                    is_sw   = 1'b1;
                    use_imm = 1'b1;
                    imm     = imm_s;
                end
            end
            OP_BR: begin
                if (funct3 == 3'b000) begin
                    is_beq = 1'b1;
                    alu_op = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Register read and ALU
    // ------------------------------------------------------------------
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] op_a, op_b;
    logic [31:0] alu_d;

    // x0 is reset to zero and never written, so a plain read returns 0.
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];
    assign op_a    = rs1_val;
    assign op_b    = use_imm ? imm : rs2_val;

    always_comb begin
        alu_d = '0;
        case (alu_op)
            ALU_ADD: alu_d = op_a + op_b;
            ALU_SUB: alu_d = op_a - op_b;
            ALU_AND: alu_d = op_a & op_b;
            ALU_OR:  alu_d = op_a | op_b;
            ALU_XOR: alu_d = op_a ^ op_b;
            ALU_SLT: alu_d = {31'b0, $signed(op_a) < $signed(op_b)};
`ifdef TOP_PROC_SHIFT_EN
            ALU_SLL: alu_d = op_a << op_b[4:0];
            ALU_SRL: alu_d = op_a >> op_b[4:0];
            ALU_SRA: alu_d = $unsigned($signed(op_a) >>> op_b[4:0]);
`endif
            default: alu_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and PC
    // ------------------------------------------------------------------
    logic [31:0] wb_data;

    assign wb_data = is_lw ? bus.dReadData : alu_q;

    always_comb begin
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID:    state_d = S_EX;
            S_EX:    state_d = S_MEM;
            S_MEM:   state_d = S_WB;
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (state_q == S_WB) begin
            if (is_beq && zero_q) pc_d = pc_q + imm_b;
            else                  pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            pc_q    <= INITIAL_PC;
            alu_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == S_EX) begin
                alu_q  <= alu_d;
                zero_q <= (alu_d == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == S_WB && reg_write && rd != 5'd0) begin
            regs_q[rd] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Gated outputs
    // ------------------------------------------------------------------
    logic in_mem;

    assign in_mem            = (state_q == S_MEM);
    assign bus.PC            = pc_q;
    assign bus.MemRead       = in_mem && is_lw;
    assign bus.MemWrite      = in_mem && is_sw;
    assign bus.dAddress      = (in_mem && (is_lw || is_sw)) ? alu_q : '0;
    assign bus.dWriteData    = (in_mem && is_sw) ? rs2_val : '0;
    assign bus.WriteBackData = (state_q == S_WB && reg_write) ? wb_data : '0;

endmodule

// File: tb/tb_rv32i_top_proc.sv
module tb_rv32i_top_proc;

    localparam logic [31:0] INIT_PC = 32'h00400000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rv32i_top_proc_if bus ();

    rv32i_top_proc #(.INITIAL_PC(INIT_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Environment memories
    logic [31:0] rom [0:255];
    logic [31:0] ram [0:63];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - INIT_PC;
        if (off < 32'd1024) return rom[off[9:2]];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        bus.instr <= rom_word(bus.PC);
        if (bus.MemWrite) ram[bus.dAddress[7:2]] <= bus.dWriteData;
        bus.dReadData <= ram[bus.dAddress[7:2]];
    end

    // Reference model: architectural state only
    logic [31:0] mregs [32];
    logic [31:0] mmem  [64];
    logic [31:0] mpc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (pc %h): got %h expected %h", tag, mpc, got, exp);
        end
    endtask

    // Encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
        input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2,
        input logic [4:0] rs1);
        return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] im;
        int          k, off;
        rd  = 5'($urandom_range(0, 9));
        rs1 = 5'($urandom_range(0, 9));
        rs2 = 5'($urandom_range(0, 9));
        f3  = 3'($urandom_range(0, 7));
        im  = 12'($urandom);
        k   = $urandom_range(0, 3);
        f7  = (k == 3) ? 7'h20 : (k == 2 && $urandom_range(0, 3) == 0) ? 7'h01 : 7'h00;
        case ($urandom_range(0, 9))
            0, 1: return enc_r(f7, rs2, rs1, f3, rd);
            2, 3: begin
                if (f3 == 3'd1 || f3 == 3'd5) im[11:5] = f7;
                return enc_i(im, rs1, f3, rd, 7'h13);
            end
            4: return enc_i(12'(4 * $urandom_range(0, 63)), 5'd0, 3'b010, rd, 7'h03);
            5: return enc_s(12'(4 * $urandom_range(0, 63)), rs2, 5'd0);
            6: begin
                off = (int'($urandom_range(0, 12)) - 4) * 4;
                if (off == 0) off = 8;
                return enc_b(13'(off), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            end
            7: begin
                if (k[0]) return enc_i(im, rs1, 3'b010, rd, 7'h03);
                return enc_s(im, rs2, rs1);
            end
            8: return $urandom;
            default: return enc_i(im, 5'd0, 3'b000, rd, 7'h13);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mpc = INIT_PC;
    endtask

    // Runs one instruction from IF (entered at a negedge) and returns at the
    // next IF negedge; with abort_mem it returns in the MEM state instead.
    task automatic run_instr(input bit abort_mem);
        logic [31:0] ins, a, b, iI, iS, iB, res, nxt, addr;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          wr, ld, st;
        ins = rom_word(mpc);
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
        a  = mregs[ins[19:15]];
        b  = mregs[ins[24:20]];
        iI = {{20{ins[31]}}, ins[31:20]};
        iS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        iB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        wr = 0; ld = 0; st = 0; res = 0; addr = 0;
        nxt = mpc + 32'd4;
        if (op == 7'h33 && f7 == 7'h00) begin
            wr = 1;
            case (f3)
                3'd0: res = a + b;
                3'd7: res = a & b;
                3'd6: res = a | b;
                3'd4: res = a ^ b;
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef TOP_PROC_SHIFT_EN
                3'd1: res = a << b[4:0];
                3'd5: res = a >> b[4:0];
`endif
                default: wr = 0;
            endcase
        end else if (op == 7'h33 && f7 == 7'h20) begin
            wr = 1;
            case (f3)
                3'd0: res = a - b;
`ifdef TOP_PROC_SHIFT_EN
                3'd5: res = $signed(a) >>> b[4:0];
`endif
                default: wr = 0;
            endcase
        end else if (op == 7'h13) begin
            wr = 1;
            case (f3)
                3'd0: res = a + iI;
                3'd7: res = a & iI;
                3'd6: res = a | iI;
                3'd4: res = a ^ iI;
                3'd2: res = ($signed(a) < $signed(iI)) ? 32'd1 : 32'd0;
`ifdef TOP_PROC_SHIFT_EN
                3'd1: if (f7 == 7'h00) res = a << ins[24:20]; else wr = 0;
                3'd5: begin
                    if (f7 == 7'h00)      res = a >> ins[24:20];
                    else if (f7 == 7'h20) res = $signed(a) >>> ins[24:20];
                    else                  wr = 0;
                end
`endif
                default: wr = 0;
            endcase
        end else if (op == 7'h03 && f3 == 3'd2) begin
            ld = 1; wr = 1;
            addr = a + iI;
            res  = mmem[addr[7:2]];
        end else if (op == 7'h23 && f3 == 3'd2) begin
            st = 1;
            addr = a + iS;
        end else if (op == 7'h63 && f3 == 3'd0) begin
            if (a == b) nxt = mpc + iB;
        end

        // IF
        check_eq("if_pc", bus.PC, mpc);
        check_eq("if_memrd", 32'(bus.MemRead), 32'd0);
        check_eq("if_memwr", 32'(bus.MemWrite), 32'd0);
        check_eq("if_daddr", bus.dAddress, 32'd0);
        check_eq("if_wbd", bus.WriteBackData, 32'd0);
        @(negedge clk); // ID
        check_eq("id_pc", bus.PC, mpc);
        @(negedge clk); // EX
        check_eq("ex_wbd", bus.WriteBackData, 32'd0);
        check_eq("ex_dwdata", bus.dWriteData, 32'd0);
        @(negedge clk); // MEM
        check_eq("mem_memrd", 32'(bus.MemRead), 32'(ld));
        check_eq("mem_memwr", 32'(bus.MemWrite), 32'(st));
        if (ld || st) check_eq("mem_daddr", bus.dAddress, addr);
        if (st) check_eq("mem_dwdata", bus.dWriteData, b);
        check_eq("mem_wbd", bus.WriteBackData, 32'd0);
        if (abort_mem) return;
        @(negedge clk); // WB
        if (wr && rd != 5'd0) check_eq("wb_data", bus.WriteBackData, res);
        check_eq("wb_memwr", 32'(bus.MemWrite), 32'd0);
        check_eq("wb_daddr", bus.dAddress, 32'd0);
        check_eq("wb_pc", bus.PC, mpc);
        if (wr && rd != 5'd0) mregs[rd] = res;
        if (st) mmem[addr[7:2]] = b;
        mpc = nxt;
        @(negedge clk); // next IF
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pc"}, bus.PC, INIT_PC);
        check_eq({tag, "_memrd"}, 32'(bus.MemRead), 32'd0);
        check_eq({tag, "_memwr"}, 32'(bus.MemWrite), 32'd0);
        check_eq({tag, "_daddr"}, bus.dAddress, 32'd0);
        check_eq({tag, "_dwdata"}, bus.dWriteData, 32'd0);
        check_eq({tag, "_wbd"}, bus.WriteBackData, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        for (int i = 0; i < 64; i++) begin
            ram[i]  = 32'h0;
            mmem[i] = 32'h0;
        end
        rom[0]  = enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'h13);       // ADDI x1,x0,5
        rom[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'h13);       // ADDI x2,x0,-3
        rom[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);          // ADD x3,x1,x2
        rom[3]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd6);          // SLT x6,x2,x1
        rom[4]  = enc_b(13'h1FF8, 5'd1, 5'd1);                     // BEQ x1,x1,-8
        rom[5]  = enc_s(12'd8, 5'd1, 5'd0);                        // SW x1,8(x0)
        rom[6]  = enc_i(12'd8, 5'd0, 3'b010, 5'd4, 7'h03);         // LW x4,8(x0)
        rom[7]  = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'h13);         // ADDI x0,x0,7
        rom[8]  = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd7);          // ADD x7,x0,x0
        rom[9]  = enc_i({7'h20, 5'd1}, 5'd2, 3'b101, 5'd5, 7'h13); // SRAI x5,x2,1
        rom[10] = enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd8);          // ADD x8,x5,x0
        rom[11] = enc_s(12'd12, 5'd3, 5'd0);                       // SW x3,12(x0)

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_instr(1'b0);   // through taken BEQ
        check_eq("beq_taken_pc", mpc, 32'h00400008);
        for (int i = 0; i < 2; i++) run_instr(1'b0);   // ADD, SLT again
        rom[4] = enc_b(13'd16, 5'd2, 5'd1);            // BEQ x1,x2,+16
        run_instr(1'b0);
        for (int i = 0; i < 6; i++) run_instr(1'b0);   // 0x14 .. 0x28

        // Abort the store at 0x2C in MEM.
        run_instr(1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        check_eq("abort_ram", ram[3], 32'd0);
        model_reset();
        // Reads of x1..x8 after reset must all be zero.
        for (int i = 0; i < 8; i++) rom[i] = enc_r(7'h00, 5'd0, 5'(i + 1), 3'b000, 5'd9);
        for (int i = 8; i < 256; i++) rom[i] = rand_instr();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 160; i++) run_instr(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_top_proc.md
# rv32i_top_proc

Multicycle RV32I-subset processor core, top-level block `top_proc`: a five-state controller plus datapath (ALU, 32×32 register file, immediate generator, PC logic). It fetches from an external synchronous-read instruction ROM (`INSTRUCTION_MEMORY`) and loads/stores through an external synchronous RAM (`DATA_MEMORY`). Every instruction takes exactly five cycles. The write-back value is exported for verification.

## Interface
- `INITIAL_PC`, default `32'h00400000`: PC value loaded on reset (byte address).
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `instr`  input  32  instruction word from ROM; valid from the cycle after IF.
- `dReadData`  input  32  RAM read data; valid in the cycle after MEM.
- `PC`  output  32  current program counter (byte address) driven to the ROM.
- `dAddress`  output  32  data memory byte address.
- `dWriteData`  output  32  store data (rs2 value).
- `MemRead`  output  1  high during the MEM state of LW.
- `MemWrite`  output  1  high during the MEM state of SW; RAM writes on the edge ending MEM.
- `WriteBackData`  output  32  value written to rd; meaningful in WB.

## Operation
- States, cyclic, unconditional: IF → ID → EX → MEM → WB → IF.
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLT.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI.
  - Memory and branch: LW, SW, BEQ.
  - Shifts (see Configuration).
  - Any other opcode executes as a NOP: no writes, PC+4.
- Immediates (I, S, B formats) are sign-extended to 32 bits. The B immediate has bit 0 = 0.
- ALU arithmetic:
  - 32-bit two's complement; wrap-around on overflow, no flags.
  - SLT/SLTI compare signed and yield 0 or 1.
  - Shift amount is operand[4:0].
- Register file:
  - Two combinational read ports, addressed by instr[19:15] and instr[24:20].
  - One write port, written on the edge ending WB.
  - x0 always reads 0; writes to x0 are discarded.
- Memory addressing: dAddress = rs1 + imm for LW/SW. No alignment checking.
- Write-back:
  - LW writes dReadData.
  - ALU instructions write the ALU result.
  - SW, BEQ and NOPs write nothing.
- PC update, on the edge ending WB only:
  - BEQ with rs1 == rs2 (ALU SUB result zero): PC + imm_B.
  - Otherwise: PC + 4.
- Output gating:
  - dAddress and dWriteData are 0 outside MEM.
  - WriteBackData is 0 outside WB.
  - MemRead and MemWrite are only ever high in MEM.

## Timing
- Reset, while rst is high:
  - PC = INITIAL_PC, state = IF, all registers x1–x31 = 0.
  - MemRead = MemWrite = 0; dAddress = dWriteData = WriteBackData = 0.
- Reset asserted mid-instruction aborts it immediately: no register-file, RAM or PC update occurs afterwards.
- After rst falls, the first rising edge ends IF. PC holds for 5 edges, then updates.
- Instruction path: the ROM registers `instr` on the edge ending IF. PC is constant until the end of WB, so `instr` stays stable ID..WB.
- Register operands are read combinationally; they are stable because no write happens before WB.
- Memory path:
  - Address and data are valid throughout MEM.
  - RAM read data is registered on the edge ending MEM and consumed in WB.
- Throughput is 1 instruction per 5 cycles; there is no pipelining or stalling.

## Configuration
- `TOP_PROC_SHIFT_EN` defined:
  - Adds SLL, SRL, SRA, SLLI, SRLI, SRAI.
  - SRA/SRAI are arithmetic shifts; the funct7[5] bit selects SRA/SRAI.
- Not defined: all shift encodings decode as NOP (no register write, PC+4) and the ALU contains no shifter.

## Test plan
- Reset:
  - Hold rst high, then release → PC = 0x00400000, MemRead = MemWrite = 0, WriteBackData = 0.
  - PC = 0x00400004 after exactly 5 rising edges.
- Arithmetic:
  - ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 → WriteBackData = 5, 0xFFFFFFFD, 2 in the respective WB cycles.
  - SLT x6,x2,x1 → 1.
- Store/load:
  - SW x1,8(x0) → in MEM: MemWrite = 1, dAddress = 8, dWriteData = 5.
  - LW x4,8(x0) → MemRead = 1 in MEM, WriteBackData = 5 in WB.
- Branch:
  - BEQ x1,x1,-8 at 0x00400010 → PC = 0x00400008.
  - BEQ x1,x2,+16 (not equal) → PC + 4.
- x0 and shifts:
  - ADDI x0,x0,7 then ADD x7,x0,x0 → 0.
  - With TOP_PROC_SHIFT_EN: SRAI x5,x2,1 → 0xFFFFFFFE.
  - Without TOP_PROC_SHIFT_EN: SRAI x5,x2,1 leaves x5 = 0, PC + 4.
- Reset mid-operation: assert rst during the MEM state of an SW → no RAM write, PC = 0x00400000, and the register file is cleared.
